fifo_pkt_reader: RTL

Drain-side engine for the sorter's output FIFOs: pops framed packets from a `sync_fifo` read port and presents them as a valid/ready stream with `m_tlast` and a header tag. It absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer. It sustains one word per cycle under continuous `m_tready`. One instance sits behind each sorted-packet FIFO, feeding the egress arbiter.

---
 rtl/fifo_pkt_pkg.sv | 25 ++
 rtl/fifo_pkt_reader_skid.sv | 73 +++++++
 rtl/fifo_pkt_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_pkt_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkt_pkg
// Shared types and constants for the sorted-packet FIFO reader:
//   - state_t : framing FSM encoding (ST_HDR, ST_PAY)
//   - HDR_LEN_LSB : LSB of the payload-length field inside the header word
//   - tag_t : per-beat sideband bundle {tlast, tuser}
// ----------------------------------------------------------------------------
package fifo_pkt_pkg;

   typedef enum logic {
      ST_HDR = 1'b0,
      ST_PAY = 1'b1
   } state_t;

   // Length field occupies header[HDR_LEN_LSB +: LEN_WIDTH].
   localparam int unsigned HDR_LEN_LSB = 0;

   localparam int unsigned TAG_WIDTH = 2;

   typedef struct packed {
      logic tlast;
      logic tuser;
   } tag_t;

endpackage

// File: rtl/fifo_pkt_reader_skid.sv
// ----------------------------------------------------------------------------
// pkt_out_skid
// Two-entry in-order output buffer holding data word plus {tlast, tuser} tag.
// Entry 0 is always the head; head outputs come straight from registers.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   i_push           : write i_push_data/i_push_tag at the tail
//   i_pop            : drop the head entry (caller only pops when o_occ != 0)
//   o_occ            : number of valid entries, 0..2
//   o_head_data/_tag : contents of the head entry
// Caller guarantees no push while full unless a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module pkt_out_skid
   import fifo_pkt_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  tag_t                  i_push_tag,
   input  logic                  i_pop,
   output logic [1:0]            o_occ,
   output logic [DATA_WIDTH-1:0] o_head_data,
   output tag_t                  o_head_tag
);

   localparam int unsigned ENT_W = DATA_WIDTH + TAG_WIDTH;

   logic [ENT_W-1:0] r_ent0;
   logic [ENT_W-1:0] r_ent1;
   logic [1:0]       r_occ;
   logic [ENT_W-1:0] w_push_ent;

   assign w_push_ent = {i_push_data, i_push_tag};

   // Shift-style buffer: pop moves entry 1 into the head slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ent0 <= '0;
         r_ent1 <= '0;
         r_occ  <= 2'd0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_ent0 <= w_push_ent;
               else               r_ent1 <= w_push_ent;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_ent0 <= r_ent1;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new word lands behind whatever remains.
               if (r_occ == 2'd2) begin
                  r_ent0 <= r_ent1;
                  r_ent1 <= w_push_ent;
               end else begin
                  r_ent0 <= w_push_ent;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_occ       = r_occ;
   assign o_head_data = r_ent0[ENT_W-1:TAG_WIDTH];
   assign o_head_tag  = tag_t'(r_ent0[TAG_WIDTH-1:0]);

endmodule

// File: rtl/fifo_pkt_reader.sv
// ----------------------------------------------------------------------------
// fifo_pkt_reader
// Pops framed packets (header + N payload words, N = header length field)
// from a sync_fifo read port with one-cycle read latency and presents them as
// a valid/ready stream with tlast/tuser tags.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   fifo_rd_data/fifo_empty : FIFO read side (data valid the cycle after read)
//   fifo_rd_en              : FIFO read request (combinational)
//   m_tdata/m_tvalid/m_tready/m_tlast/m_tuser : output stream, tuser=header
//   pkt_count               : packets whose last beat has been handshaked
// ----------------------------------------------------------------------------
module fifo_pkt_reader
   import fifo_pkt_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic                  m_tuser,
   output logic [CNT_WIDTH-1:0]  pkt_count
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic [LEN_WIDTH-1:0]  w_remaining_nxt;
   logic                  r_inflight;
   logic [CNT_WIDTH-1:0]  r_pkt_count;

   logic [LEN_WIDTH-1:0]  w_hdr_len;
   tag_t                  w_cap_tag;
   tag_t                  w_head_tag;
   logic [1:0]            w_occ;
   logic                  w_pop;
   logic [2:0]            w_level;

   assign w_hdr_len = fifo_rd_data[HDR_LEN_LSB +: LEN_WIDTH];

   // Read issue: keep buffered + in-flight words at most 2 after this cycle's pop.
   assign m_tvalid   = (w_occ != 2'd0);
   assign w_pop      = m_tvalid && m_tready;
   assign w_level    = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
   assign fifo_rd_en = rst_n && !fifo_empty && (w_level < 3'd2);

   // Framing state, in-flight flag and packet counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_HDR;
         r_remaining <= '0;
         r_inflight  <= 1'b0;
         r_pkt_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_inflight  <= fifo_rd_en;
         if (w_pop && w_head_tag.tlast) r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
      end
   end

   // Framing FSM: advances only when a word is captured from the FIFO.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_cap_tag       = '0;
      if (r_inflight) begin
         case (r_state)
            ST_HDR: begin
               w_cap_tag.tuser = 1'b1;
               w_cap_tag.tlast = (w_hdr_len == '0);
               if (w_hdr_len != '0) begin
                  w_remaining_nxt = w_hdr_len;
                  w_state_nxt     = ST_PAY;
               end
            end
            ST_PAY: begin
               w_cap_tag.tuser = 1'b0;
               w_cap_tag.tlast = (r_remaining == LEN_WIDTH'(1));
               if (r_remaining != '0) w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
               if (r_remaining <= LEN_WIDTH'(1)) w_state_nxt = ST_HDR;
            end
            default: w_state_nxt = ST_HDR;
         endcase
      end
   end

   pkt_out_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (r_inflight),
      .i_push_data (fifo_rd_data),
      .i_push_tag  (w_cap_tag),
      .i_pop       (w_pop),
      .o_occ       (w_occ),
      .o_head_data (m_tdata),
      .o_head_tag  (w_head_tag)
   );

   assign m_tlast   = w_head_tag.tlast;
   assign m_tuser   = w_head_tag.tuser;
   assign pkt_count = r_pkt_count;

endmodule
